// File: rtl/serial_parity_checker.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Parity sense is even by default; defining PARITY_ODD_EN selects odd parity.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | line idle, waiting for a 0 start bit
// S_DATA   | collecting DATA_W data bits into r_shift
// S_PARITY | sampling the parity bit, latching the mismatch
// S_STOP   | sampling the stop bit, registering the results
module serial_parity_checker #(
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

`ifdef PARITY_ODD_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_count;
    logic              r_acc;
    logic              r_perr;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data;
    logic              r_fv;
    logic              r_perr_out;
    logic              r_ferr_out;
    logic              w_busy;

    assign w_busy = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_acc      <= 1'b0;
            r_perr     <= 1'b0;
            r_shift    <= '0;
            r_data     <= '0;
            r_fv       <= 1'b0;
            r_perr_out <= 1'b0;
            r_ferr_out <= 1'b0;
        end else begin
            // frame_valid is a single-cycle strobe regardless of bit_valid
            r_fv <= 1'b0;
            if (bit_valid) begin
                case (r_state)
                    S_IDLE: begin
                        if (!bit_in) begin
                            r_count <= '0;
                            r_acc   <= 1'b0;
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        for (int i = 0; i < DATA_W; i++) begin
                            if (r_count == CNT_W'(i)) r_shift[i] <= bit_in;
                        end
                        r_acc   <= r_acc ^ bit_in;
                        r_count <= r_count + 1'b1;
                        if (r_count == CNT_W'(DATA_W - 1)) r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_perr  <= r_acc ^ bit_in ^ ODD;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        r_data     <= r_shift;
                        r_perr_out <= r_perr;
                        r_ferr_out <= ~bit_in;
                        r_fv       <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign data_out    = r_data;
    assign frame_valid = r_fv;
    assign parity_err  = r_perr_out;
    assign frame_err   = r_ferr_out;
    assign busy        = w_busy;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker (DATA_W=3) with a queue scoreboard of frames.
// Expected parity follows PARITY_ODD_EN the same way the design build does.
module tb_serial_parity_checker;

    localparam int DW = 3;

`ifdef PARITY_ODD_EN
    localparam logic TB_ODD = 1'b1;
`else
    localparam logic TB_ODD = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bit_in = 1'b1;
    logic          bit_valid = 1'b0;
    logic [DW-1:0] data_out;
    logic          frame_valid;
    logic          parity_err;
    logic          frame_err;
    logic          busy;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   pulse_q[$];
    logic [DW-1:0] last_data;

    serial_parity_checker #(.DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .data_out    (data_out),
        .frame_valid (frame_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every frame_valid pulse must match the oldest pushed frame.
    always @(negedge clk) begin
        if (frame_valid) begin
            pulse_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("data_out", 32'(data_out), 32'(e.data));
                chk("parity_err", 32'(parity_err), 32'(e.perr));
                chk("frame_err", 32'(frame_err), 32'(e.ferr));
                last_data = e.data;
            end
        end
    end

    task automatic step(input logic v, input logic b);
        bit_valid = v;
        bit_in    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        step(1'b1, b);
        for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s, input int gap);
        exp_t e;
        e.data = d;
        e.perr = (^d) ^ p ^ TB_ODD;
        e.ferr = ~s;
        exp_q.push_back(e);
        send_bit(1'b0, 0);
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < DW; i++) send_bit(d[i], gap);
        send_bit(p, gap);
        chk("fv_before_stop", 32'(frame_valid), 32'd0);
        step(1'b1, s);
        chk("fv_after_stop", 32'(frame_valid), 32'd1);
        chk("busy_after_stop", 32'(busy), 32'd0);
    endtask

    initial begin
        int n0;
        // reset for two cycles with idle line
        rst = 1'b1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_frame_valid", 32'(frame_valid), 32'd0);
        chk("rst_parity_err", 32'(parity_err), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("idle_busy", 32'(busy), 32'd0);

        // good frame 0,1,0,1,0,1
        send_frame(3'b101, 1'b0, 1'b1, 0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("hold_data_out", 32'(data_out), 32'(last_data));
        chk("fv_single_cycle", 32'(frame_valid), 32'd0);

        // data 3'b011 with parity 0 then with parity 1
        send_frame(3'b011, 1'b0, 1'b1, 0);
        step(1'b1, 1'b1);
        send_frame(3'b011, 1'b1, 1'b1, 0);
        step(1'b1, 1'b1);

        // framing error with 2-cycle gaps: 0,1,1,1,1,0
        n0 = pulse_q.size();
        send_frame(3'b111, 1'b1, 1'b0, 2);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1);
        chk("gap_pulse_count", 32'(pulse_q.size() - n0), 32'd1);

        // back-to-back frames 3'b101 then 3'b110
        step(1'b1, 1'b1);
        n0 = pulse_q.size();
        send_frame(3'b101, 1'b0, 1'b1, 0);
        send_frame(3'b110, 1'b0, 1'b1, 0);
        step(1'b1, 1'b1);
        chk("b2b_pulse_count", 32'(pulse_q.size() - n0), 32'd2);
        if (pulse_q.size() - n0 == 2)
            chk("b2b_spacing", 32'(pulse_q[n0+1] - pulse_q[n0]), 32'd6);

        // mid-frame reset after 3 bits, then a full frame
        n0 = pulse_q.size();
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b1);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_data_out", 32'(data_out), 32'd0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1);
        chk("midrst_no_pulse", 32'(pulse_q.size() - n0), 32'd0);
        send_frame(3'b010, 1'b1, 1'b1, 0);
        step(1'b1, 1'b1);

        // a few random frames with random gaps
        for (int r = 0; r < 6; r++) begin
            send_frame(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
            if (r[0]) step(1'b1, 1'b1);
        end
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
